// File: rtl/sparse_pkg.sv
// Shared widths and FSM encoding for the sparse dot-product reader.
package sparse_pkg;

    localparam int DW   = 8;
    localparam int IW   = 8;
    localparam int AW   = 4;
    localparam int ACCW = 2 * DW + AW;

    localparam logic [AW:0] MAX_LEN = (AW + 1)'(2 ** AW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Lengths beyond the memory depth are treated as a full memory.
    function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Unsigned DW x DW multiply with an ACCW-wide accumulator; clear wins over enable.
import sparse_pkg::*;

module mac_unit (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);

    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] acc_d, acc_q;

    assign prod = a * b;

    always_comb begin
        acc_d = acc_q;
        if (clear)
            acc_d = '0;
        else if (en)
            acc_d = acc_q + ACCW'(prod);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/sparse_dot_reader.sv
// Two-pointer merge over two sorted (index, value) memories, accumulating the
// dot product of matching indices.
import sparse_pkg::*;

module sparse_dot_reader (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW:0]     len1,
    input  logic [AW:0]     len2,
    output logic            rd_en,
    output logic [AW-1:0]   addr1r,
    output logic [AW-1:0]   addr2r,
    input  logic [IW-1:0]   idx1,
    input  logic [DW-1:0]   val1,
    input  logic [IW-1:0]   idx2,
    input  logic [DW-1:0]   val2,
    output logic            busy,
    output logic            done,
    output logic [ACCW-1:0] result,
    output logic [AW:0]     match_cnt
);

    state_e        state_d, state_q;
    logic [AW:0]   p1_d, p1_q, p2_d, p2_q;
    logic [AW:0]   len1_d, len1_q, len2_d, len2_q;
    logic [AW:0]   match_d, match_q;
    logic [AW-1:0] addr1_d, addr1_q, addr2_d, addr2_q;
    logic          rd_en_d, rd_en_q, busy_d, busy_q, done_d, done_q;

    logic [AW:0]   l1_c, l2_c, p1_n, p2_n;
    logic          accept, hit;

    assign l1_c   = clamp_len(len1);
    assign l2_c   = clamp_len(len2);
    assign accept = (state_q == IDLE) && start;
    assign hit    = (state_q == CMP) && (idx1 == idx2);

    // Pointer advance for the current compare; pointers are AW+1 bits so 16 stays distinct from 0.
    always_comb begin
        p1_n = p1_q;
        p2_n = p2_q;
        if (idx1 <= idx2) p1_n = p1_q + (AW + 1)'(1);
        if (idx1 >= idx2) p2_n = p2_q + (AW + 1)'(1);
    end

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        len1_d  = len1_q;
        len2_d  = len2_q;
        match_d = match_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        busy_d  = busy_q;
        rd_en_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len1_d  = l1_c;
                    len2_d  = l2_c;
                    p1_d    = '0;
                    p2_d    = '0;
                    match_d = '0;
                    busy_d  = 1'b1;
                    if (l1_c == '0 || l2_c == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        rd_en_d = 1'b1;
                        addr1_d = '0;
                        addr2_d = '0;
                    end
                end
            end
            FETCH: state_d = CMP;
            CMP: begin
                p1_d = p1_n;
                p2_d = p2_n;
                if (idx1 == idx2) match_d = match_q + (AW + 1)'(1);
                if (p1_n == len1_q || p2_n == len2_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FETCH;
                    rd_en_d = 1'b1;
                    addr1_d = p1_n[AW-1:0];
                    addr2_d = p2_n[AW-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            len1_q  <= '0;
            len2_q  <= '0;
            match_q <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            len1_q  <= len1_d;
            len2_q  <= len2_d;
            match_q <= match_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    mac_unit u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (hit),
        .a     (val1),
        .b     (val2),
        .acc   (result)
    );

    assign rd_en     = rd_en_q;
    assign addr1r    = addr1_q;
    assign addr2r    = addr2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = match_q;

endmodule

// File: doc/sparse_dot_reader.md
Name: sparse_dot_reader

Overview:
- Read-side consumer of the dual index/value memory (index_mem).
- Each of the two sparse vectors is stored as (index, value) pairs with indices strictly ascending from address 0.
- On `start`, the block walks both memories with a two-pointer merge, multiplies values whose indices match, and accumulates a dot product.
- Reports the result, the match count and a `done` pulse. It sits between index_mem and the downstream result display/checker.

Parameters:
- DW, 8: value width
- IW, 8: index width
- AW, 4: memory address width (depth 2**AW = 16)
- ACCW, 20: accumulator width (2*DW+AW); holds 16 × 255 × 255 without overflow

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- len1  in  AW+1  number of valid entries in memory 1 (0..16); latched on accepted start
- len2  in  AW+1  number of valid entries in memory 2 (0..16); latched on accepted start
- rd_en  out  1  read strobe to both memories
- addr1r  out  AW  read address, memory 1
- addr2r  out  AW  read address, memory 2
- idx1  in  IW  index read from memory 1; valid one cycle after rd_en
- val1  in  DW  value read from memory 1; valid one cycle after rd_en
- idx2  in  IW  index read from memory 2; valid one cycle after rd_en
- val2  in  DW  value read from memory 2; valid one cycle after rd_en
- busy  out  1  high from FETCH through DONE inclusive
- done  out  1  one-cycle pulse in DONE
- result  out  ACCW  dot product; holds until next accepted start
- match_cnt  out  AW+1  number of matched index pairs

Behaviour:
- Clock and reset: one clock (`clk`); reset is asynchronous and active-high (`reset`).
- Reset values: state=IDLE, p1=p2=0, rd_en=0, addr1r=addr2r=0, busy=0, done=0, result=0, match_cnt=0.
- Reset asserted mid-operation aborts the walk immediately and returns all outputs to their reset values.
- State machine: IDLE, FETCH, CMP, DONE.
- IDLE:
  - On start=1: latch len1/len2, clamping values above 16 to 16.
  - Clear result, match_cnt, p1 and p2.
  - If either latched length is 0 → DONE; otherwise → FETCH.
- FETCH:
  - rd_en=1, addr1r=p1, addr2r=p2.
  - → CMP. Memory read latency is exactly 1 cycle.
- CMP: rd_en=0; idx/val inputs are valid this cycle.
  - idx1 == idx2: result += val1*val2 (unsigned, zero-extended to ACCW); match_cnt += 1; p1 += 1; p2 += 1.
  - idx1 < idx2 (unsigned): p1 += 1.
  - idx1 > idx2: p2 += 1.
  - If the updated p1 == len1 or the updated p2 == len2 → DONE; otherwise → FETCH.
  - Pointers are AW+1 bits wide, so reaching 16 is not aliased to 0.
- DONE: done=1 for one cycle, then → IDLE.
- Latency: start accepted at cycle k with N CMP iterations → done at cycle k+2N+1. With an empty input, done is at k+1.
- start while not in IDLE is ignored, with no effect on the walk.
- start asserted in the same cycle done pulses is ignored; the earliest restart is the cycle after done.
- Input contract: unsorted or duplicate indices are a caller error. The block still terminates within len1+len2 iterations; the result is unspecified.
- Arithmetic: ACCW is sized so the accumulator cannot overflow. No saturation logic.

Decomposition:
- Shared package `sparse_pkg`:
  - width constants DW, IW, AW, ACCW;
  - state encoding IDLE=2'd0, FETCH=2'd1, CMP=2'd2, DONE=2'd3.
- One natural sub-module, `mac_unit`: an 8×8 unsigned multiply plus ACCW accumulate, with clear and enable inputs.
- Merge control and pointers stay in the top level.

Test Plan:
- Partial overlap: mem1 idx {1,3,5} val {2,4,6}, mem2 idx {3,5,7} val {10,10,10}, len1=len2=3 → result=100, match_cnt=2, 3 iterations, done at k+7.
- Empty input: len1=0, len2=5 → no rd_en pulses, done at k+1, result=0, match_cnt=0.
- Full identical vectors: idx 0..15 in both, all values 255, len=16/16 → result=1040400, match_cnt=16, done at k+33; addr never wraps to 0 after entry 15.
- Disjoint vectors: mem1 even idx 0..14, mem2 odd idx 1..15, len 8/8 → result=0, match_cnt=0, done asserted.
- Start ignored and reset abort: start pulsed again mid-walk → no restart and the result matches the single-run result. reset pulsed during CMP → busy=0, done=0, result=0 immediately; a fresh start then completes correctly.
